// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: drives the datapath controls for each state and counts retired instructions.
// Outputs are combinational from state (FETCH is Mealy on mem_ready); memory waits stall in FETCH/MEMRD/MEMWR.
module multicycle_control #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode,
  input  logic            mem_ready,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            memtoreg,
  output logic            irwrite,
  output logic            alusrca,
  output logic            regwrite,
  output logic            regdst,
  output logic            aluop1,
  output logic            aluop0,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsource,
  output logic [3:0]      state,
  output logic            illegal,
  output logic [CNTW-1:0] instret
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RWB    = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ORIEX  = 4'd10;
  localparam logic [3:0] ORIWB  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  logic [3:0]      state_q;
  logic [3:0]      state_d;
  logic            retire;
  logic            mrdy;
  logic [CNTW-1:0] instret_q;

  // Holding mem_ready low under reset keeps the FETCH write enables quiet.
  assign mrdy    = mem_ready & rst_n;
  assign state   = state_q;
  assign instret = instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    case (state_q)
      FETCH:  state_d = mrdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ORI:       state_d = ORIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = mrdy ? MEMWB : MEMRD;
      MEMWB:  retire  = 1'b1;
      MEMWR: begin
        state_d = mrdy ? FETCH : MEMWR;
        retire  = mrdy;
      end
      EXEC:   state_d = RWB;
      RWB:    retire  = 1'b1;
      BRANCH: retire  = 1'b1;
      JUMP:   retire  = 1'b1;
      ORIEX:  state_d = ORIWB;
      ORIWB:  retire  = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mrdy;
        pcwrite = mrdy;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ORI});
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
      end
      RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop1  = 1'b1;
        aluop0  = 1'b1;
      end
      ORIWB: regwrite = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNTW'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams against a path-level model.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst;
  logic aluop1, aluop0, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic [15:0] instret;

  logic pcwrite2, pcwritecond2, iord2, memread2, memwrite2, memtoreg2, irwrite2, alusrca2, regwrite2, regdst2;
  logic aluop12, aluop02, illegal2;
  logic [1:0] alusrcb2, pcsource2;
  logic [3:0] state2;
  logic [1:0] instret2;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .alusrca(alusrca),
    .regwrite(regwrite), .regdst(regdst), .aluop1(aluop1), .aluop0(aluop0),
    .alusrcb(alusrcb), .pcsource(pcsource), .state(state), .illegal(illegal), .instret(instret)
  );

  multicycle_control #(.CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .iord(iord2), .memread(memread2),
    .memwrite(memwrite2), .memtoreg(memtoreg2), .irwrite(irwrite2), .alusrca(alusrca2),
    .regwrite(regwrite2), .regdst(regdst2), .aluop1(aluop12), .aluop0(aluop02),
    .alusrcb(alusrcb2), .pcsource(pcsource2), .state(state2), .illegal(illegal2), .instret(instret2)
  );

  logic [16:0] ctrl;
  assign ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca,
                 regwrite, regdst, aluop1, aluop0, alusrcb, pcsource, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic is_legal(logic [5:0] op);
    return op inside {6'd35, 6'd43, 6'd0, 6'd4, 6'd2, 6'd13};
  endfunction

  // Expected control vector for a state, written straight from the per-state control table.
  function automatic logic [16:0] exp_ctrl(int s, logic mr, logic [5:0] op);
    logic pw, pwc, io, mrd, mwr, m2r, irw, asa, rw, rd, a1, a0, ill;
    logic [1:0] sb, ps;
    {pw, pwc, io, mrd, mwr, m2r, irw, asa, rw, rd, a1, a0, ill} = '0;
    sb = 2'b00;
    ps = 2'b00;
    case (s)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1:  begin sb = 2'b11; ill = !is_legal(op); end
      2:  begin asa = 1; sb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin asa = 1; a1 = 1; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; a0 = 1; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; sb = 2'b10; a1 = 1; a0 = 1; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, io, mrd, mwr, m2r, irw, asa, rw, rd, a1, a0, sb, ps, ill};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'd0;
    #3;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (instret !== 16'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
    n_checks++; if (ctrl !== 17'b00010000000001000) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 17'b00010000000001000); end
    #20;
    n_checks++; if (state !== 4'd0 || irwrite !== 1'b0) begin n_fail++; $display("FAIL reset_hold: state %0d irwrite %b want 0/0", state, irwrite); end
  endtask

  task automatic test_rtype;
    do_reset;
    opcode = 6'd0;
    mem_ready = 1'b1;
    #2;
    n_checks++; if (state !== 4'd0 || irwrite !== 1'b1 || pcwrite !== 1'b1) begin n_fail++; $display("FAIL rtype_fetch: state %0d irwrite %b pcwrite %b want 0/1/1", state, irwrite, pcwrite); end
    cyc;
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL rtype_decode: got %0d want 1", state); end
    cyc;
    n_checks++; if (state !== 4'd6 || {aluop1, aluop0} !== 2'b10) begin n_fail++; $display("FAIL rtype_exec: state %0d aluop %b%b want 6/10", state, aluop1, aluop0); end
    cyc;
    n_checks++; if (state !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1 || instret !== 16'd0) begin n_fail++; $display("FAIL rtype_rwb: state %0d regdst %b regwrite %b instret %0d want 7/1/1/0", state, regdst, regwrite, instret); end
    cyc;
    n_checks++; if (state !== 4'd0 || instret !== 16'd1) begin n_fail++; $display("FAIL rtype_retire: state %0d instret %0d want 0/1", state, instret); end
  endtask

  task automatic test_lw_wait;
    do_reset;
    opcode = 6'd35;
    mem_ready = 1'b1;
    repeat (3) cyc;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #2;
      n_checks++; if (state !== 4'd3 || iord !== 1'b1 || memread !== 1'b1) begin n_fail++; $display("FAIL lw_memrd_%0d: state %0d iord %b memread %b want 3/1/1", i, state, iord, memread); end
      cyc;
    end
    n_checks++; if (state !== 4'd4 || memtoreg !== 1'b1 || regwrite !== 1'b1 || instret !== 16'd0) begin n_fail++; $display("FAIL lw_memwb: state %0d memtoreg %b regwrite %b instret %0d want 4/1/1/0", state, memtoreg, regwrite, instret); end
    cyc;
    n_checks++; if (state !== 4'd0 || instret !== 16'd1) begin n_fail++; $display("FAIL lw_retire: state %0d instret %0d want 0/1", state, instret); end
  endtask

  task automatic test_illegal;
    do_reset;
    opcode = 6'h3f;
    mem_ready = 1'b1;
    #2;
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_in_fetch: got %b want 0", illegal); end
    cyc;
    n_checks++; if (state !== 4'd1 || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_decode: state %0d illegal %b want 1/1", state, illegal); end
    cyc;
    n_checks++; if (state !== 4'd0 || illegal !== 1'b0 || instret !== 16'd0) begin n_fail++; $display("FAIL illegal_return: state %0d illegal %b instret %0d want 0/0/0", state, illegal, instret); end
  endtask

  task automatic test_ori;
    do_reset;
    opcode = 6'd13;
    mem_ready = 1'b1;
    repeat (2) cyc;
    n_checks++; if (state !== 4'd10 || {aluop1, aluop0} !== 2'b11 || alusrcb !== 2'b10) begin n_fail++; $display("FAIL ori_ex: state %0d aluop %b%b alusrcb %b want 10/11/10", state, aluop1, aluop0, alusrcb); end
    cyc;
    n_checks++; if (state !== 4'd11 || regwrite !== 1'b1 || regdst !== 1'b0) begin n_fail++; $display("FAIL ori_wb: state %0d regwrite %b regdst %b want 11/1/0", state, regwrite, regdst); end
    cyc;
    n_checks++; if (instret !== 16'd1) begin n_fail++; $display("FAIL ori_retire: got %0d want 1", instret); end
  endtask

  task automatic test_reset_mid_memwr;
    do_reset;
    opcode = 6'd2;
    mem_ready = 1'b1;
    repeat (3) cyc;
    opcode = 6'd43;
    repeat (3) cyc;
    mem_ready = 1'b0;
    #2;
    n_checks++; if (state !== 4'd5 || memwrite !== 1'b1 || instret !== 16'd1) begin n_fail++; $display("FAIL sw_memwr: state %0d memwrite %b instret %0d want 5/1/1", state, memwrite, instret); end
    #2 rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++; if (state !== 4'd0 || memwrite !== 1'b0 || instret !== 16'd0) begin n_fail++; $display("FAIL async_reset: state %0d memwrite %b instret %0d want 0/0/0", state, memwrite, instret); end
    n_checks++; if (memread !== 1'b1 || alusrcb !== 2'b01 || irwrite !== 1'b0 || pcwrite !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_ctrl: memread %b alusrcb %b irwrite %b pcwrite %b want 1/01/0/0", memread, alusrcb, irwrite, pcwrite); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    n_checks++; if (state !== 4'd0 || irwrite !== 1'b1 || memwrite !== 1'b0) begin n_fail++; $display("FAIL post_reset_fetch: state %0d irwrite %b memwrite %b want 0/1/0", state, irwrite, memwrite); end
    cyc;
    n_checks++; if (state !== 4'd1 || memwrite !== 1'b0 || regwrite !== 1'b0) begin n_fail++; $display("FAIL post_reset_decode: state %0d memwrite %b regwrite %b want 1/0/0", state, memwrite, regwrite); end
  endtask

  task automatic test_wrap;
    logic [1:0] want2 [4];
    want2 = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset;
    opcode = 6'd2;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (3) cyc;
      n_checks++; if (instret2 !== want2[i] || instret !== 16'(i + 1)) begin n_fail++; $display("FAIL wrap_%0d: narrow %0d wide %0d want %0d/%0d", i, instret2, instret, want2[i], i + 1); end
    end
  endtask

  // Each instruction is modelled as its list of visited states; FETCH/MEMRD/MEMWR stall while mem_ready is low.
  task automatic test_random;
    int path[$];
    int exp_ret;
    int es;
    int idx;
    int kind;
    logic [5:0] op;
    logic [16:0] want;
    do_reset;
    exp_ret = 0;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin op = 6'd35; path = '{0, 1, 2, 3, 4}; end
        1: begin op = 6'd43; path = '{0, 1, 2, 5}; end
        2: begin op = 6'd0;  path = '{0, 1, 6, 7}; end
        3: begin op = 6'd4;  path = '{0, 1, 8}; end
        4: begin op = 6'd2;  path = '{0, 1, 9}; end
        5: begin op = 6'd13; path = '{0, 1, 10, 11}; end
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
          path = '{0, 1};
        end
      endcase
      idx = 0;
      while (idx < path.size()) begin
        es = path[idx];
        opcode = (es == 1 || es == 2) ? op : 6'($urandom);
        mem_ready = ($urandom_range(0, 3) != 0);
        #2;
        want = exp_ctrl(es, mem_ready, opcode);
        n_checks++; if (state !== 4'(es) || state2 !== 4'(es)) begin n_fail++; $display("FAIL rand_state i%0d: got %0d/%0d want %0d", n, state, state2, es); end
        n_checks++; if (ctrl !== want) begin n_fail++; $display("FAIL rand_ctrl i%0d s%0d: got %b want %b", n, es, ctrl, want); end
        n_checks++; if (instret !== 16'(exp_ret) || instret2 !== 2'(exp_ret)) begin n_fail++; $display("FAIL rand_instret i%0d: got %0d/%0d want %0d", n, instret, instret2, exp_ret); end
        if (!((es == 0 || es == 3 || es == 5) && !mem_ready)) begin
          idx++;
          if (idx == path.size() && kind != 6) exp_ret++;
        end
        cyc;
      end
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_lw_wait;
    test_illegal;
    test_ori;
    test_reset_mid_memwr;
    test_wrap;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNTW, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register; valid from DECODE onward.
REQ-005 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have ports pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst  output  1 each  datapath controls.
REQ-007 SHALL have ports aluop1, aluop0  output  1 each  ALU control select; 00 add, 01 sub, 10 R-type funct, 11 or.
REQ-008 SHALL have ports alusrcb, pcsource  output  2 each  ALU B mux select and PC source select.
REQ-009 SHALL have port state  output  4  current state encoding.
REQ-010 SHALL have port illegal  output  1  unsupported opcode decoded.
REQ-011 SHALL have port instret  output  CNTW  retired-instruction count.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ORIEX=10, ORIWB=11; codes 12-15 SHALL go to FETCH next cycle with all controls deasserted.
REQ-013 Unlisted outputs SHALL be 0 in every state.
REQ-014 FETCH: memread=1, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready (Mealy); hold until mem_ready=1, then DECODE.
REQ-015 DECODE: alusrcb=11, aluop=00; next by opcode: 100011 or 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001101 -> ORIEX, otherwise FETCH with illegal=1 for that cycle only.
REQ-016 MEMADR: alusrca=1, alusrcb=10, aluop=00; opcode 100011 -> MEMRD, else MEMWR.
REQ-017 MEMRD: memread=1, iord=1; hold until mem_ready=1, then MEMWB.
REQ-018 MEMWB: memtoreg=1, regdst=0, regwrite=1; -> FETCH.
REQ-019 MEMWR: memwrite=1, iord=1; hold until mem_ready=1, then FETCH.
REQ-020 EXEC: alusrca=1, alusrcb=00, aluop=10; -> RWB.  RWB: regdst=1, regwrite=1; -> FETCH.
REQ-021 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01; -> FETCH.
REQ-022 JUMP: pcwrite=1, pcsource=10; -> FETCH.
REQ-023 ORIEX: alusrca=1, alusrcb=10, aluop=11; -> ORIWB.  ORIWB: regdst=0, regwrite=1; -> FETCH.
REQ-024 instret SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR (on mem_ready), RWB, BRANCH, JUMP or ORIWB; not on illegal or invalid-state returns; wraps 2^CNTW-1 -> 0.
REQ-025 Cycle counts with mem_ready tied 1: R-type/ori 4, lw 5, sw 4, beq 3, j 3, illegal 2.
REQ-026 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-027 opcode changes during wait states SHALL not alter transitions except in DECODE and MEMADR.

Reset
REQ-028 rst_n=0 SHALL immediately force state=FETCH and instret=0, independent of clk.
REQ-029 During reset, outputs SHALL follow FETCH decode with mem_ready forced low internally: memread=1, alusrcb=01, all write enables (pcwrite, irwrite, memwrite, regwrite, pcwritecond) 0.
REQ-030 Reset asserted mid-MEMWR or mid-MEMRD SHALL abandon the access; no memwrite/regwrite after rst_n rises until a new instruction reaches that state.
REQ-031 First rising clk after rst_n deasserts SHALL evaluate FETCH normally.

Verification
REQ-032 Reset, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; regdst=regwrite=1 in RWB; instret 0->1.
REQ-033 opcode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=memread=1 throughout, then MEMWB with memtoreg=1; instret +1.
REQ-034 opcode=111111 -> DECODE shows illegal=1 one cycle, returns FETCH, instret unchanged.
REQ-035 opcode=001101 -> ORIEX aluop1=aluop0=1, alusrcb=10; ORIWB regwrite=1, regdst=0.
REQ-036 rst_n pulsed low mid-MEMWR (mem_ready=0) -> state=0 asynchronously, memwrite=0, instret=0.
REQ-037 CNTW=2, four j instructions -> instret 1,2,3,0.
